lab3_serial_cla_adder: RTL and testbench
========================================

LAB3_SERIAL_CLA_ADDER -- requirements
Module: lab3_serial_cla_adder

Interface
REQ-001 Parameter: N_NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIB.
REQ-002 Port clk, input, 1 -- sole clock, all state updates on rising edge.
REQ-003 Port rst_n, input, 1 -- asynchronous, active-low reset.
REQ-004 Port start, input, 1 -- request; sampled on rising clk edge.
REQ-005 Port X, input, W -- addend A, captured when start is accepted.
REQ-006 Port Y, input, W -- addend B, captured when start is accepted.
REQ-007 Port Cin, input, 1 -- carry-in to bit 0, captured when start is accepted.
REQ-008 Port busy, output, 1 -- high while an operation is in progress.
REQ-009 Port done, output, 1 -- one-cycle pulse; Sum, Cout and Overflow are valid and final.
REQ-010 Port Sum, output, W -- registered sum X+Y+Cin modulo 2^W.
REQ-011 Port Cout, output, 1 -- carry out of bit W-1.
REQ-012 Port Overflow, output, 1 -- signed overflow: carry into bit W-1 XOR Cout.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at an edge: capture X, Y, Cin; nibble index := 0; state := RUN.
REQ-015 RUN: one nibble per cycle, LSB nibble first, through the 4-bit carry-lookahead adder (P=X^Y, G=X&Y, c[i+1]=G[i]|P[i]&c[i]).
- Nibble sum written to Sum[4i+3:4i].
- Nibble carry-out registered as carry-in for nibble i+1.
REQ-016 RUN, last nibble (i=N_NIB-1): register Cout and Overflow; state := DONE.
REQ-017 Latency: start accepted at edge k gives done=1 in the cycle following edge k+N_NIB (N_NIB+1 cycles start-to-done).
REQ-018 busy=1 exactly in the RUN cycles; done=1 exactly in the DONE cycle; busy and done never both 1.
REQ-019 start while busy is ignored; X, Y and Cin changes during RUN have no effect on the result.
REQ-020 DONE returns to IDLE at the next edge, unless start=1 at that edge: then capture new operands and go to RUN (back-to-back, no idle bubble).
REQ-021 Sum, Cout and Overflow hold their values from the DONE cycle until the next operation's final edge.
- Partial nibbles of a new operation may appear in Sum during RUN.
- Cout and Overflow change only at the final edge.
REQ-022 Arithmetic is modulo 2^W; X=Y=all-ones with Cin=1 gives Sum=all-ones and Cout=1.

Reset
REQ-023 rst_n=0 forces immediately, regardless of clk: state=IDLE, nibble index=0, internal carry=0, busy=0, done=0, Sum=0, Cout=0, Overflow=0.
REQ-024 Reset during RUN aborts the operation; no done pulse follows; start is first accepted at the first edge after rst_n rises.

Structure
REQ-025 Shared package holds:
- State enum (IDLE, RUN, DONE).
- Constant NIB_W = 4.
- Index-width helper, clog2 of N_NIB.
REQ-026 One sub-module: lab3_cla4_add, combinational 4-bit carry-lookahead adder with ports X[3:0], Y[3:0], Cin in and Sum[3:0], Cout, C3 out (C3 = carry into bit 3, used for Overflow), instantiated once.
REQ-027 Operand shift/select, carry register and FSM live in the top module; no other sub-modules.

Verification (N_NIB=4)
REQ-028 X=16'h1234, Y=16'h4321, Cin=0, start pulse -> done in 5th cycle after start edge, Sum=16'h5555, Cout=0, Overflow=0; busy high exactly 4 cycles.
REQ-029 X=16'hFFFF, Y=16'h0000, Cin=1 -> Sum=16'h0000, Cout=1, Overflow=0 (full ripple across all nibble boundaries).
REQ-030 X=16'h7FFF, Y=16'h0001, Cin=0 -> Sum=16'h8000, Cout=0, Overflow=1; X=16'h8000, Y=16'h8000 -> Sum=0, Cout=1, Overflow=1.
REQ-031 Start held high for 10 cycles with X/Y toggling during RUN -> first result from the operands captured at the first edge; second operation captured in the DONE cycle; two done pulses 5 cycles apart.
REQ-032 rst_n low in the 2nd RUN cycle -> all outputs 0 immediately, no done pulse; new start after release yields a correct result.
REQ-033 Random regression of 10k operations with randomized start gaps -> {Cout,Sum} equals X+Y+Cin and Overflow matches the signed reference model on every done.

Source files
------------

// File: rtl/lab3_serial_cla_adder_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
// The index width helper never returns 0 so single-nibble builds still get a counter bit.
package lab3_serial_cla_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n_nib);
    return (n_nib > 1) ? $clog2(n_nib) : 1;
  endfunction

endpackage

// File: rtl/lab3_cla4_add.sv
// Combinational 4-bit carry-lookahead adder; C3 is the carry into the top bit,
// exported so the caller can form signed overflow.
module lab3_cla4_add
  import lab3_serial_cla_adder_pkg::*;
(
  input  logic [NIB_W-1:0] X,
  input  logic [NIB_W-1:0] Y,
  input  logic             Cin,
  output logic [NIB_W-1:0] Sum,
  output logic             Cout,
  output logic             C3
);

  logic [NIB_W-1:0] w_p;
  logic [NIB_W-1:0] w_g;
  logic [NIB_W:0]   w_c;

  assign w_p = X ^ Y;
  assign w_g = X & Y;

  // Every carry is expanded from G/P and Cin directly, no ripple between stages.
  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign Sum  = w_p ^ w_c[NIB_W-1:0];
  assign Cout = w_c[NIB_W];
  assign C3   = w_c[NIB_W-1];

endmodule

// File: rtl/lab3_serial_cla_adder.sv
// Serial adder: one nibble per cycle through a single 4-bit CLA, LSB nibble first.
// Handshake: start is taken in IDLE or DONE; busy marks RUN cycles; done pulses one cycle with results final.
module lab3_serial_cla_adder
  import lab3_serial_cla_adder_pkg::*;
#(
  parameter int N_NIB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*N_NIB-1:0] X,
  input  logic [4*N_NIB-1:0] Y,
  input  logic               Cin,
  output logic               busy,
  output logic               done,
  output logic [4*N_NIB-1:0] Sum,
  output logic               Cout,
  output logic               Overflow,
  output logic [1:0]         dbg_state
);

  localparam int W  = NIB_W * N_NIB;
  localparam int IW = idx_w(N_NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_NIB - 1);

  state_t         r_state;
  state_t         w_next;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic           r_ovf;

  logic [NIB_W-1:0] w_nib_sum;
  logic             w_nib_cout;
  logic             w_nib_c3;
  logic             w_accept;
  logic             w_last;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == LAST_IDX);

  lab3_cla4_add u_cla (
    .X    (r_x[NIB_W-1:0]),
    .Y    (r_y[NIB_W-1:0]),
    .Cin  (r_carry),
    .Sum  (w_nib_sum),
    .Cout (w_nib_cout),
    .C3   (w_nib_c3)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Operands shift right so the CLA always sees the current nibble in bits [3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_x     <= X;
      r_y     <= Y;
      r_carry <= Cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[NIB_W*r_idx +: NIB_W] <= w_nib_sum;
      r_x     <= r_x >> NIB_W;
      r_y     <= r_y >> NIB_W;
      r_carry <= w_nib_cout;
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_cout  <= w_nib_cout;
        r_ovf   <= w_nib_c3 ^ w_nib_cout;
        r_idx   <= '0;
        r_carry <= 1'b0;
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lab3_serial_cla_adder.sv
// Directed and random checks of the nibble-serial CLA adder with N_NIB=4.
module tb_lab3_serial_cla_adder;

  localparam int N_NIB = 4;
  localparam int W     = 4 * N_NIB;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Overflow;
  logic [1:0]   dbg_state;

  int errors;
  int checks;

  lab3_serial_cla_adder #(.N_NIB(N_NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .X         (X),
    .Y         (Y),
    .Cin       (Cin),
    .busy      (busy),
    .done      (done),
    .Sum       (Sum),
    .Cout      (Cout),
    .Overflow  (Overflow),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {overflow, cout, sum} from plain integer addition and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full};
  endfunction

  // Launches one operation and waits (bounded) for done; optional noise on
  // start/X/Y/Cin during RUN cycles only.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit noise, output logic [W-1:0] s, output logic co,
                        output logic ov, output int lat, output int bcnt, output int both);
    lat = -1; bcnt = 0; both = 0; s = '0; co = 1'b0; ov = 1'b0;
    @(negedge clk);
    start = 1'b1; X = a; Y = b; Cin = c;
    for (int m = 1; m <= 20 && lat < 0; m++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (busy && done) both++;
      if (done) begin
        lat = m; s = Sum; co = Cout; ov = Overflow;
      end
      if (noise && m <= 3) begin
        start = 1'($urandom_range(0, 1));
        X     = W'($urandom);
        Y     = W'($urandom);
        Cin   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, Sum, Cout, Overflow, dbg_state} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b Sum=%h Cout=%b Ovf=%b st=%0d, required all 0",
               busy, done, Sum, Cout, Overflow, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] s, input logic co,
                              input logic ov, input int lat, input logic [W-1:0] es,
                              input logic eco, input logic eov);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within 20 cycles, required done at cycle 5", name);
    end else if ({s, co, ov} !== {es, eco, eov}) begin
      errors++;
      $display("FAIL %s: Sum=%h Cout=%b Ovf=%b, required Sum=%h Cout=%b Ovf=%b",
               name, s, co, ov, es, eco, eov);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co, ov; int lat, bcnt, both;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, s, co, ov, lat, bcnt, both);
    check_result("basic", s, co, ov, lat, 16'h5555, 1'b0, 1'b0);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL basic_latency: done at cycle %0d, required 5", lat);
    end
    checks++;
    if (bcnt !== 4) begin
      errors++; $display("FAIL basic_busy_cycles: busy for %0d cycles, required 4", bcnt);
    end
    checks++;
    if (both !== 0) begin
      errors++; $display("FAIL basic_busy_done_overlap: %0d cycles, required 0", both);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, Sum} !== {1'b0, 1'b0, 16'h5555}) begin
      errors++;
      $display("FAIL basic_hold: done=%b busy=%b Sum=%h, required 0 0 5555", done, busy, Sum);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] s; logic co, ov; int lat, bcnt, both;
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b1, s, co, ov, lat, bcnt, both);
    check_result("ripple", s, co, ov, lat, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, s, co, ov, lat, bcnt, both);
    check_result("pos_overflow", s, co, ov, lat, 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b1, s, co, ov, lat, bcnt, both);
    check_result("neg_overflow", s, co, ov, lat, 16'h0000, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, s, co, ov, lat, bcnt, both);
    check_result("all_ones", s, co, ov, lat, 16'hFFFF, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n_done, m1, m2;
    logic [W-1:0] s1, s2; logic c1, c2, o1, o2;
    n_done = 0; m1 = -1; m2 = -1; s1 = '0; s2 = '0; c1 = 0; c2 = 0; o1 = 0; o2 = 0;
    @(negedge clk);
    start = 1'b1; X = 16'h1111; Y = 16'h2222; Cin = 1'b1;
    for (int m = 1; m <= 14; m++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin m1 = m; s1 = Sum; c1 = Cout; o1 = Overflow; end
        else if (n_done == 2) begin m2 = m; s2 = Sum; c2 = Cout; o2 = Overflow; end
      end
      if (m == 5) begin
        X = 16'hA5A5; Y = 16'h5A5A; Cin = 1'b1;
      end else if (m < 10) begin
        X = W'($urandom); Y = W'($urandom); Cin = 1'($urandom_range(0, 1));
      end
      if (m == 10) start = 1'b0;
    end
    checks++;
    if (n_done !== 2 || m1 !== 5 || m2 !== 10) begin
      errors++;
      $display("FAIL b2b_timing: %0d dones at cycles %0d,%0d, required 2 at 5,10", n_done, m1, m2);
    end
    check_result("b2b_first", s1, c1, o1, m1, 16'h3334, 1'b0, 1'b0);
    check_result("b2b_second", s2, c2, o2, m2, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int n_done, lat;
    logic [W-1:0] s; logic co, ov; int bcnt, both;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, s, co, ov, lat, bcnt, both);
    check_result("pre_reset", s, co, ov, lat, 16'hFFFE, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; X = 16'h4444; Y = 16'h3333; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Sum, Cout, Overflow} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b Sum=%h Cout=%b Ovf=%b, required all 0",
               busy, done, Sum, Cout, Overflow);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++; $display("FAIL reset_no_done: %0d done pulses after abort, required 0", n_done);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; X = 16'h0F0F; Y = 16'h00F1; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_first_start: busy=%b, required 1", busy);
    end
    lat = -1; s = '0; co = 1'b0; ov = 1'b0;
    for (int m = 2; m <= 20 && lat < 0; m++) begin
      @(negedge clk);
      if (done) begin lat = m; s = Sum; co = Cout; ov = Overflow; end
    end
    check_result("post_reset", s, co, ov, lat, 16'h1000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s; logic c, co, ov; int lat, bcnt, both;
    logic [W+1:0] exp_v;
    for (int n = 0; n < 10000; n++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom_range(0, 1));
      exp_v = model(a, b, c);
      run_op(a, b, c, 1'b1, s, co, ov, lat, bcnt, both);
      checks++;
      if (lat !== 5 || {ov, co, s} !== exp_v) begin
        errors++;
        $display("FAIL random_%0d: %h+%h+%b lat=%0d got Ovf=%b Cout=%b Sum=%h, required lat=5 Ovf=%b Cout=%b Sum=%h",
                 n, a, b, c, lat, ov, co, s, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
